// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Push-button front end for the RGB PWM brightness stage. Each raw button pin
// is polarity-normalised, passed through a 2-FF synchroniser, debounced, and
// auto-repeated by an independent per-button FSM.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   btn_raw    raw button pins, asynchronous to clk
//   btn_level  debounced pressed state, 1 = pressed
//   btn_step   one-clock pulse on an accepted press and on each repeat
//   btn_hold   1 while the button is in auto-repeat
//
// Optional feature (compile-time macro BTN_ACCEL_EN):
//   When defined, each button counts its repeat steps, which are cleared on
//   entry to HOLD and saturate at 8. Once 8 repeats have occurred, the repeat
//   interval shortens to REPEAT_CYC>>2, with a floor of 2 cycles. When the
//   macro is undefined, the repeat interval is always REPEAT_CYC and no
//   counting logic is built.
//
// All *_CYC parameters must satisfy 2 <= value < 2**CNT_W.
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int NUM_BTN        = 6,
    parameter int CNT_W          = 24,
    parameter int DEBOUNCE_CYC   = 135000,
    parameter int HOLD_DELAY_CYC = 13500000,
    parameter int REPEAT_CYC     = 2700000,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_step,
    output logic [NUM_BTN-1:0] btn_hold
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS_DB = 3'd1,
        ST_HOLD     = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_REL_DB   = 3'd4
    } state_t;

    // Counters compare against "period - 1" because they start at 0 on the
    // edge on which a state is entered.
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HD_LAST  = CNT_W'(HOLD_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_BTN-1:0] norm_s;
    logic [NUM_BTN-1:0] sync1_r;
    logic [NUM_BTN-1:0] sync2_r;

    state_t             state_r      [NUM_BTN];
    state_t             state_nxt_s  [NUM_BTN];
    logic [CNT_W-1:0]   cnt_r        [NUM_BTN];
    logic [CNT_W-1:0]   cnt_nxt_s    [NUM_BTN];
    logic [CNT_W-1:0]   rpt_last_s   [NUM_BTN];
    logic [NUM_BTN-1:0] step_evt_r;
    logic [NUM_BTN-1:0] step_evt_nxt_s;

    logic [NUM_BTN-1:0] level_s;
    logic [NUM_BTN-1:0] hold_s;

    // Normalise polarity so that 1 always means "pressed" downstream.
    always_comb begin
        if (ACTIVE_LOW != 0) begin
            norm_s = ~btn_raw;
        end else begin
            norm_s = btn_raw;
        end
    end

    // Two-stage synchroniser; clears to "not pressed".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= {NUM_BTN{1'b0}};
            sync2_r <= {NUM_BTN{1'b0}};
        end else begin
            sync1_r <= norm_s;
            sync2_r <= sync1_r;
        end
    end

`ifdef BTN_ACCEL_EN
    localparam int FAST_CYC = ((REPEAT_CYC >> 2) < 2) ? 2 : (REPEAT_CYC >> 2);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_CYC - 1);

    logic [3:0] rep_r     [NUM_BTN];
    logic [3:0] rep_nxt_s [NUM_BTN];

    // Repeat interval per button: fast once 8 repeats have been issued.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            if (rep_r[i] == 4'd8) begin
                rpt_last_s[i] = FAST_LAST;
            end else begin
                rpt_last_s[i] = RPT_LAST;
            end
        end
    end

    // Repeat-step count: cleared on any entry to HOLD, otherwise bumped on
    // each repeat step and saturated at 8. The press step always enters HOLD,
    // so the clear takes priority over the increment.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            rep_nxt_s[i] = rep_r[i];
            if ((state_nxt_s[i] == ST_HOLD) && (state_r[i] != ST_HOLD)) begin
                rep_nxt_s[i] = 4'd0;
            end else if (step_evt_nxt_s[i] && (rep_r[i] != 4'd8)) begin
                rep_nxt_s[i] = rep_r[i] + 4'd1;
            end else begin
                rep_nxt_s[i] = rep_r[i];
            end
        end
    end

    // Repeat-step count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                rep_r[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                rep_r[i] <= rep_nxt_s[i];
            end
        end
    end
`else
    // Fixed repeat interval.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            rpt_last_s[i] = RPT_LAST;
        end
    end
`endif

    // State register: FSM state, cycle counter and pending step event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= {CNT_W{1'b0}};
            end
            step_evt_r <= {NUM_BTN{1'b0}};
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_r[i] <= state_nxt_s[i];
                cnt_r[i]   <= cnt_nxt_s[i];
            end
            step_evt_r <= step_evt_nxt_s;
        end
    end

    // Next-state logic. A step event is flagged on the transition edge itself
    // and surfaces one clock later through the output register.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            state_nxt_s[i]    = state_r[i];
            cnt_nxt_s[i]      = cnt_r[i];
            step_evt_nxt_s[i] = 1'b0;
            case (state_r[i])
                ST_IDLE: begin
                    cnt_nxt_s[i] = {CNT_W{1'b0}};
                    if (sync2_r[i]) begin
                        state_nxt_s[i] = ST_PRESS_DB;
                    end else begin
                        state_nxt_s[i] = ST_IDLE;
                    end
                end
                ST_PRESS_DB: begin
                    if (!sync2_r[i]) begin
                        state_nxt_s[i] = ST_IDLE;
                        cnt_nxt_s[i]   = {CNT_W{1'b0}};
                    end else if (cnt_r[i] == DB_LAST) begin
                        state_nxt_s[i]    = ST_HOLD;
                        cnt_nxt_s[i]      = {CNT_W{1'b0}};
                        step_evt_nxt_s[i] = 1'b1;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (!sync2_r[i]) begin
                        state_nxt_s[i] = ST_REL_DB;
                        cnt_nxt_s[i]   = {CNT_W{1'b0}};
                    end else if (cnt_r[i] == HD_LAST) begin
                        state_nxt_s[i]    = ST_REPEAT;
                        cnt_nxt_s[i]      = {CNT_W{1'b0}};
                        step_evt_nxt_s[i] = 1'b1;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (!sync2_r[i]) begin
                        state_nxt_s[i] = ST_REL_DB;
                        cnt_nxt_s[i]   = {CNT_W{1'b0}};
                    end else if (cnt_r[i] == rpt_last_s[i]) begin
                        cnt_nxt_s[i]      = {CNT_W{1'b0}};
                        step_evt_nxt_s[i] = 1'b1;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                    end
                end
                ST_REL_DB: begin
                    // A bounce back to pressed re-arms the hold delay
                    // without issuing a fresh press step.
                    if (sync2_r[i]) begin
                        state_nxt_s[i] = ST_HOLD;
                        cnt_nxt_s[i]   = {CNT_W{1'b0}};
                    end else if (cnt_r[i] == DB_LAST) begin
                        state_nxt_s[i] = ST_IDLE;
                        cnt_nxt_s[i]   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s[i] = ST_IDLE;
                    cnt_nxt_s[i]   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode from the current state.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            case (state_r[i])
                ST_HOLD: begin
                    level_s[i] = 1'b1;
                    hold_s[i]  = 1'b0;
                end
                ST_REPEAT: begin
                    level_s[i] = 1'b1;
                    hold_s[i]  = 1'b1;
                end
                ST_REL_DB: begin
                    level_s[i] = 1'b1;
                    hold_s[i]  = 1'b0;
                end
                default: begin
                    level_s[i] = 1'b0;
                    hold_s[i]  = 1'b0;
                end
            endcase
        end
    end

    // Registered outputs; reset forces them low immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level <= {NUM_BTN{1'b0}};
            btn_step  <= {NUM_BTN{1'b0}};
            btn_hold  <= {NUM_BTN{1'b0}};
        end else begin
            btn_level <= level_s;
            btn_step  <= step_evt_r;
            btn_hold  <= hold_s;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Directed scenarios followed by randomized button activity. A reference model
// describes each button by its debounce run length and its hold age since the
// press was accepted; the outputs after edge n reflect the input sampled at
// edge n-3 (two synchroniser stages plus the registered output).
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int NB = 6;
    localparam int CW = 8;
    localparam int DB = 4;
    localparam int HD = 20;
    localparam int RC = 8;
    localparam int AL = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_step;
    logic [NB-1:0] btn_hold;

    btn_conditioner #(
        .NUM_BTN       (NB),
        .CNT_W         (CW),
        .DEBOUNCE_CYC  (DB),
        .HOLD_DELAY_CYC(HD),
        .REPEAT_CYC    (RC),
        .ACTIVE_LOW    (AL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_step (btn_step),
        .btn_hold (btn_hold)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = -1;

    // Reference model state per button.
    bit m_lvl  [NB];
    int m_run  [NB];   // consecutive samples disagreeing with the accepted level
    int m_age  [NB];   // pressed samples since the hold timer (re)started
    int m_next [NB];   // age at which the next step is due
    int m_reps [NB];   // repeat steps since the hold timer (re)started
    bit m_step [NB];
    bit h1 [NB];
    bit h2 [NB];
    bit h3 [NB];

    logic [NB-1:0] exp_level, exp_step, exp_hold;
    logic [NB-1:0] prev_lvl_d, prev_hold_d, prev_lvl_m, prev_hold_m;

    // Event logs: kind*10000 + button*1000 + cycle (1 step, 2 level fall, 3 hold rise)
    int ev_dut[$];
    int ev_mdl[$];
    int exp_ev[$];

    function automatic int next_gap(int reps);
`ifdef BTN_ACCEL_EN
        if (reps >= 8) return ((RC >> 2) < 2) ? 2 : (RC >> 2);
        return RC;
`else
        return RC + 0 * reps;
`endif
    endfunction

    task automatic chk(string name, logic [NB-1:0] act, logic [NB-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d act=%b exp=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int b = 0; b < NB; b++) begin
            m_lvl[b] = 1'b0; m_run[b] = 0; m_age[b] = 0; m_next[b] = HD;
            m_reps[b] = 0; m_step[b] = 1'b0;
            h1[b] = 1'b0; h2[b] = 1'b0; h3[b] = 1'b0;
        end
    endtask

    task automatic restart_hold(int b);
        m_age[b] = 0; m_next[b] = HD; m_reps[b] = 0;
    endtask

    // One model step for button b given pressed sample s.
    task automatic mdl_edge(int b, bit s);
        m_step[b] = 1'b0;
        if (!m_lvl[b]) begin
            if (s) begin
                m_run[b]++;
                if (m_run[b] == DB + 1) begin
                    m_lvl[b] = 1'b1; m_run[b] = 0; restart_hold(b); m_step[b] = 1'b1;
                end
            end else begin
                m_run[b] = 0;
            end
        end else if (!s) begin
            m_run[b]++;
            if (m_run[b] == DB + 1) begin
                m_lvl[b] = 1'b0; m_run[b] = 0;
            end
        end else if (m_run[b] > 0) begin
            m_run[b] = 0; restart_hold(b);
        end else begin
            m_age[b]++;
            if (m_age[b] == m_next[b]) begin
                m_step[b] = 1'b1;
                if (m_reps[b] < 8) m_reps[b]++;
                m_next[b] = m_age[b] + next_gap(m_reps[b]);
            end
        end
    endtask

    // Compare process: advance the model on every edge, check #1 later.
    always begin
        @(posedge clk);
        if (rst) begin
            mdl_clear();
            cyc = -1;
            #1;
            chk("rst_level", btn_level, '0);
            chk("rst_step",  btn_step,  '0);
            chk("rst_hold",  btn_hold,  '0);
            prev_lvl_d = '0; prev_hold_d = '0; prev_lvl_m = '0; prev_hold_m = '0;
        end else begin
            cyc = cyc + 1;
            for (int b = 0; b < NB; b++) begin
                bit pr, s;
                pr = (AL != 0) ? ~btn_raw[b] : btn_raw[b];
                s = h3[b]; h3[b] = h2[b]; h2[b] = h1[b]; h1[b] = pr;
                mdl_edge(b, s);
                exp_level[b] = m_lvl[b];
                exp_step[b]  = m_step[b];
                exp_hold[b]  = m_lvl[b] && (m_run[b] == 0) && (m_age[b] >= HD);
            end
            #1;
            chk("level", btn_level, exp_level);
            chk("step",  btn_step,  exp_step);
            chk("hold",  btn_hold,  exp_hold);
            for (int b = 0; b < NB; b++) begin
                if (btn_step[b])                       ev_dut.push_back(10000 + 1000 * b + cyc);
                if (prev_lvl_d[b] && !btn_level[b])    ev_dut.push_back(20000 + 1000 * b + cyc);
                if (!prev_hold_d[b] && btn_hold[b])    ev_dut.push_back(30000 + 1000 * b + cyc);
                if (exp_step[b])                       ev_mdl.push_back(10000 + 1000 * b + cyc);
                if (prev_lvl_m[b] && !exp_level[b])    ev_mdl.push_back(20000 + 1000 * b + cyc);
                if (!prev_hold_m[b] && exp_hold[b])    ev_mdl.push_back(30000 + 1000 * b + cyc);
            end
            prev_lvl_d = btn_level; prev_hold_d = btn_hold;
            prev_lvl_m = exp_level; prev_hold_m = exp_hold;
        end
    end

    // Reset for two cycles, release at a falling edge; next rising edge is cycle 0.
    task automatic start_test();
        @(negedge clk);
        rst = 1'b1;
        btn_raw = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ev_dut.delete();
        ev_mdl.delete();
    endtask

    task automatic drive(logic [NB-1:0] raw, int n);
        btn_raw = raw;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_events(string name);
        chk_int({name, "_count_dut"}, ev_dut.size(), exp_ev.size());
        chk_int({name, "_count_mdl"}, ev_mdl.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size(); i++) begin
            if (i < ev_dut.size()) chk_int({name, "_ev_dut"}, ev_dut[i], exp_ev[i]);
            if (i < ev_mdl.size()) chk_int({name, "_ev_mdl"}, ev_mdl[i], exp_ev[i]);
        end
    endtask

    // Assert reset asynchronously mid-cycle and check outputs drop at once.
    task automatic async_reset_check(string name);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk({name, "_level"}, btn_level, '0);
        chk({name, "_step"},  btn_step,  '0);
        chk({name, "_hold"},  btn_hold,  '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ev_dut.delete();
        ev_mdl.delete();
    endtask

    initial begin
        int run_left [NB];
        logic [NB-1:0] rnd_raw;

        rst = 1'b1;
        btn_raw = '1;
        mdl_clear();
        repeat (3) @(negedge clk);

        // Bounce: no run of pressed samples is long enough.
        start_test();
        drive(6'b111110, 3);
        drive(6'b111111, 2);
        drive(6'b111110, 3);
        drive(6'b111111, 15);
        exp_ev.delete();
        check_events("bounce");

        // Clean press of button 0 for 12 cycles.
        start_test();
        drive(6'b111110, 12);
        drive(6'b111111, 12);
        exp_ev = '{10007, 20019};
        check_events("clean_press");

        // Long hold of button 2.
        start_test();
        drive(6'b111011, 70);
        drive(6'b111111, 12);
        exp_ev = '{12007, 12027, 32027, 12035, 12043, 12051, 12059, 12067, 22077};
        check_events("long_hold");

        // Simultaneous presses on 0 and 5, button 3 three cycles later.
        start_test();
        drive(6'b011110, 3);
        drive(6'b010110, 12);
        drive(6'b010111, 2);
        drive(6'b011111, 4);
        drive(6'b111111, 12);
        exp_ev = '{10007, 15007, 13010, 20022, 23024, 25028};
        check_events("simultaneous");

        // Reset during REPEAT with button 1 held through reset release.
        start_test();
        drive(6'b111101, 40);
        async_reset_check("mid_repeat_rst");
        drive(6'b111101, 12);
        drive(6'b111111, 12);
        exp_ev = '{11007, 21019};
        check_events("after_rst");

`ifdef BTN_ACCEL_EN
        // Accelerated repeat on button 4.
        start_test();
        drive(6'b101111, 150);
        drive(6'b111111, 12);
        exp_ev = '{14007, 14027, 34027};
        for (int t = 35; t <= 83; t += 8) exp_ev.push_back(14000 + t);
        for (int t = 85; t <= 151; t += 2) exp_ev.push_back(14000 + t);
        exp_ev.push_back(24157);
        check_events("accel");
`endif

        // Randomized activity on all buttons, one asynchronous reset midway.
        start_test();
        rnd_raw = '1;
        for (int b = 0; b < NB; b++) run_left[b] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int b = 0; b < NB; b++) begin
                if (run_left[b] == 0) begin
                    rnd_raw[b]  = 1'($urandom_range(0, 1));
                    run_left[b] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 6))
                                                              : int'($urandom_range(8, 60));
                end
                run_left[b]--;
            end
            btn_raw = rnd_raw;
            if (c == 1200) begin
                async_reset_check("rand_rst");
            end else begin
                @(negedge clk);
            end
        end
        drive(6'b111111, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
